// File: rtl/jtcps1_tilemap_sched_if.sv
// rtl/jtcps1_tilemap_sched_if.sv - engine and shared-memory bus bundle for the tilemap scheduler
//
// Engine side (packed {e2,e1,e0}):
//   eng_start     scheduler -> engine one-hot start pulse
//   eng_done      engine -> scheduler done level
//   eng_vram_*    per-engine VRAM request (addr/cs) and routed ok
//   eng_rom_*     per-engine GFX ROM request (addr/half/cs) and routed ok
//   eng_buf_*     per-engine line-buffer write (addr/data/wr)
// Shared side:
//   vram_*        single VRAM port (addr/cs out, ok in)
//   rom_*         single GFX ROM port (addr/half/cs out, ok in)
//   buf_*         single line-buffer write port, data tagged with layer id
// master modport belongs to the scheduler, slave to engines/memories.
interface jtcps1_tilemap_sched_if;
    logic [2:0]  eng_start;
    logic [2:0]  eng_done;
    logic [68:0] eng_vram_addr;
    logic [2:0]  eng_vram_cs;
    logic [68:0] eng_rom_addr;
    logic [2:0]  eng_rom_half;
    logic [2:0]  eng_rom_cs;
    logic [26:0] eng_buf_addr;
    logic [26:0] eng_buf_data;
    logic [2:0]  eng_buf_wr;
    logic [2:0]  eng_vram_ok;
    logic [2:0]  eng_rom_ok;
    logic [22:0] vram_addr;
    logic        vram_cs;
    logic        vram_ok;
    logic [22:0] rom_addr;
    logic        rom_half;
    logic        rom_cs;
    logic        rom_ok;
    logic [8:0]  buf_addr;
    logic [10:0] buf_data;
    logic        buf_wr;

    modport master (
        output eng_start, eng_vram_ok, eng_rom_ok,
        output vram_addr, vram_cs, rom_addr, rom_half, rom_cs,
        output buf_addr, buf_data, buf_wr,
        input  eng_done, eng_vram_addr, eng_vram_cs, eng_rom_addr, eng_rom_half,
        input  eng_rom_cs, eng_buf_addr, eng_buf_data, eng_buf_wr,
        input  vram_ok, rom_ok
    );

    modport slave (
        input  eng_start, eng_vram_ok, eng_rom_ok,
        input  vram_addr, vram_cs, rom_addr, rom_half, rom_cs,
        input  buf_addr, buf_data, buf_wr,
        output eng_done, eng_vram_addr, eng_vram_cs, eng_rom_addr, eng_rom_half,
        output eng_rom_cs, eng_buf_addr, eng_buf_data, eng_buf_wr,
        output vram_ok, rom_ok
    );
endinterface

// File: rtl/jtcps1_tilemap_sched.sv
// rtl/jtcps1_tilemap_sched.sv - per-line sequencer for the three scroll-layer tilemap engines
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_line_start       one-cycle pulse starting a line
//   i_v, i_layer_en    line number and layer enables, latched on an accepted line_start
//   bus                engine/shared-port bundle (master side)
//   o_v_lat            latched line number
//   o_busy             sequence in progress
//   o_line_done        one-cycle pulse when all layers are handled
//   o_overrun          one-cycle pulse when line_start arrives while not idle
//   o_timeout_flags    sticky per-layer watchdog flags
module jtcps1_tilemap_sched #(
    parameter int TIMEOUT = 1536,
    parameter int CW      = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_line_start,
    input  logic [8:0]                    i_v,
    input  logic [2:0]                    i_layer_en,
    jtcps1_tilemap_sched_if.master        bus,
    output logic [8:0]                    o_v_lat,
    output logic                          o_busy,
    output logic                          o_line_done,
    output logic                          o_overrun,
    output logic [2:0]                    o_timeout_flags
);
    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_START, S_ARM, S_WAIT, S_FIN
    } state_t;

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_pending;
    logic [1:0]    r_k;
    logic [1:0]    w_sel_k;
    logic [CW-1:0] r_wdog;
    logic [8:0]    r_v_lat;
    logic [2:0]    r_tflags;
    logic [22:0]   r_vram_addr;
    logic [22:0]   r_rom_addr;
    logic          r_rom_half;
    logic [8:0]    r_buf_addr;
    logic [10:0]   r_buf_data;

    logic          w_active;
    logic          w_done_k;
    logic          w_wd_exp;
    logic [22:0]   w_vaddr [3];
    logic [22:0]   w_raddr [3];
    logic [8:0]    w_baddr [3];
    logic [8:0]    w_bpix  [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_vaddr[i] = bus.eng_vram_addr[i*23 +: 23];
            w_raddr[i] = bus.eng_rom_addr[i*23 +: 23];
            w_baddr[i] = bus.eng_buf_addr[i*9 +: 9];
            w_bpix[i]  = bus.eng_buf_data[i*9 +: 9];
        end
    end

    // Lowest-numbered layer still waiting its turn this line.
    always_comb begin
        w_sel_k = 2'd2;
        if (r_pending[0])      w_sel_k = 2'd0;
        else if (r_pending[1]) w_sel_k = 2'd1;
    end

    assign w_active = (r_state == S_START) || (r_state == S_ARM) || (r_state == S_WAIT);
    assign w_done_k = bus.eng_done[r_k];
    assign w_wd_exp = (r_wdog == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_line_start) w_next = S_SEL;
            S_SEL:   w_next = (r_pending == 3'b000) ? S_FIN : S_START;
            S_START: w_next = S_ARM;
            S_ARM:   w_next = S_WAIT;
            S_WAIT:  if (w_done_k || w_wd_exp) w_next = S_SEL;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_k         <= '0;
            r_wdog      <= '0;
            r_v_lat     <= '0;
            r_tflags    <= '0;
            r_vram_addr <= '0;
            r_rom_addr  <= '0;
            r_rom_half  <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_line_start) begin
                        r_v_lat   <= i_v;
                        r_pending <= i_layer_en;
                        r_tflags  <= 3'b000;
                    end
                end
                S_SEL:   r_k <= w_sel_k;
                S_START: r_wdog <= '0;
                S_WAIT: begin
                    r_wdog <= r_wdog + CW'(1);
                    if (w_done_k || w_wd_exp) r_pending[r_k] <= 1'b0;
                    // done in the expiry cycle counts as a normal finish
                    if (!w_done_k && w_wd_exp) r_tflags[r_k] <= 1'b1;
                end
                default: ;
            endcase
            // Shared addresses keep the last routed value once the window closes.
            if (w_active) begin
                r_vram_addr <= w_vaddr[r_k];
                r_rom_addr  <= w_raddr[r_k];
                r_rom_half  <= bus.eng_rom_half[r_k];
                r_buf_addr  <= w_baddr[r_k];
                r_buf_data  <= {r_k, w_bpix[r_k]};
            end
        end
    end

    always_comb begin
        o_busy          = (r_state != S_IDLE) && (r_state != S_FIN);
        o_line_done     = (r_state == S_FIN);
        o_overrun       = i_line_start && (r_state != S_IDLE);
        o_v_lat         = r_v_lat;
        o_timeout_flags = r_tflags;
        bus.eng_start   = (r_state == S_START) ? (3'b001 << r_k) : 3'b000;
        // Strobes derive from state only, so reset drops them without a clock.
        bus.vram_cs     = w_active && bus.eng_vram_cs[r_k];
        bus.rom_cs      = w_active && bus.eng_rom_cs[r_k];
        bus.buf_wr      = w_active && bus.eng_buf_wr[r_k];
        bus.vram_addr   = w_active ? w_vaddr[r_k]          : r_vram_addr;
        bus.rom_addr    = w_active ? w_raddr[r_k]          : r_rom_addr;
        bus.rom_half    = w_active ? bus.eng_rom_half[r_k] : r_rom_half;
        bus.buf_addr    = w_active ? w_baddr[r_k]          : r_buf_addr;
        bus.buf_data    = w_active ? {r_k, w_bpix[r_k]}    : r_buf_data;
        bus.eng_vram_ok = (w_active && bus.vram_ok) ? (3'b001 << r_k) : 3'b000;
        bus.eng_rom_ok  = (w_active && bus.rom_ok)  ? (3'b001 << r_k) : 3'b000;
    end
endmodule
